sram_wr_port_arbiter: RTL and testbench

//  Multiplexes N_REQ writeback requesters onto the N_WP write ports of a multi-ported SRAM
//  (rename map / PRF arrays).
//  - Each requester has a small FIFO. Up to N_WP heads are granted per cycle, round-robin.
//  - Same-address collisions within a cycle are resolved so the SRAM never sees two writes
//    to one index.
//  - Drives the SRAM weN/addrNwr/dataNwr inputs directly from registers.

---
 rtl/sram_wr_port_arbiter_pkg.sv | 25 ++
 rtl/sram_wr_port_arbiter_if.sv | 27 ++
 rtl/sram_wr_port_arbiter_wr_req_fifo.sv | 53 +++++
 rtl/sram_wr_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_wr_port_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_wr_port_arbiter_pkg.sv
// Shared types and helpers for the SRAM write-port arbiter.
package sram_wr_port_arbiter_pkg;

    localparam int REQ_ADDR_W     = 4;
    localparam int REQ_DATA_W     = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    function automatic int clog2(input int n);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // One queued write; the field widths set the SRAM index/data widths of the whole block.
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/sram_wr_port_arbiter_if.sv
// Requester and SRAM-side bus of the write-port arbiter.
interface sram_wr_port_arbiter_if #(
    parameter int N_REQ      = 6,
    parameter int N_WP       = 4,
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 8
);
    logic                          flush_i;
    logic [N_REQ-1:0]              req_valid_i;
    logic [N_REQ*SRAM_INDEX-1:0]   req_addr_i;
    logic [N_REQ*SRAM_WIDTH-1:0]   req_data_i;
    logic [N_REQ-1:0]              req_ready_o;
    logic [N_WP-1:0]               we_o;
    logic [N_WP*SRAM_INDEX-1:0]    addr_wr_o;
    logic [N_WP*SRAM_WIDTH-1:0]    data_wr_o;
    logic                          busy_o;

    modport master (
        output flush_i, req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o, we_o, addr_wr_o, data_wr_o, busy_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_addr_i, req_data_i,
        output req_ready_o, we_o, addr_wr_o, data_wr_o, busy_o
    );
endinterface

// File: rtl/sram_wr_port_arbiter_wr_req_fifo.sv
// Per-requester write FIFO; flush and reset both empty it, flush also drops a same-cycle push.
module wr_req_fifo
    import sram_wr_port_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  wr_req_t din_i,
    output wr_req_t head_o,
    output logic    empty_o,
    output logic    full_o
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    pop_nonempty: assert property (@(posedge clk) disable iff (!reset) !(pop_i && empty_o));

endmodule

// File: rtl/sram_wr_port_arbiter.sv
// Round-robin arbiter mapping queued requester writes onto the SRAM write ports,
// never issuing two writes to one index in the same cycle.
module sram_wr_port_arbiter
    import sram_wr_port_arbiter_pkg::*;
#(
    parameter int N_REQ      = 6,
    parameter int N_WP       = 4,
    parameter int SRAM_INDEX = REQ_ADDR_W,
    parameter int SRAM_WIDTH = REQ_DATA_W,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_wr_port_arbiter_if.slave bus
);
    localparam int RRW = clog2(N_REQ);

    wr_req_t               din   [N_REQ];
    wr_req_t               head  [N_REQ];
    logic [N_REQ-1:0]      push;
    logic [N_REQ-1:0]      pop;
    logic [N_REQ-1:0]      empty;
    logic [N_REQ-1:0]      full;
    logic [N_REQ-1:0]      ready;

    logic [N_WP-1:0]       we_d, we_q;
    logic [SRAM_INDEX-1:0] addr_d [N_WP];
    logic [SRAM_INDEX-1:0] addr_q [N_WP];
    logic [SRAM_WIDTH-1:0] data_d [N_WP];
    logic [SRAM_WIDTH-1:0] data_q [N_WP];
    logic [RRW-1:0]        rr_ptr_d, rr_ptr_q;

    for (genvar r = 0; r < N_REQ; r++) begin : g_req
        assign din[r]   = {bus.req_addr_i[r*SRAM_INDEX +: SRAM_INDEX],
                           bus.req_data_i[r*SRAM_WIDTH +: SRAM_WIDTH]};
        // Ready reflects only the FIFO fill level, never this cycle's dequeue.
        assign ready[r] = reset & ~full[r];
        assign push[r]  = bus.req_valid_i[r] & ready[r] & ~bus.flush_i;

        wr_req_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush_i (bus.flush_i),
            .push_i  (push[r]),
            .pop_i   (pop[r]),
            .din_i   (din[r]),
            .head_o  (head[r]),
            .empty_o (empty[r]),
            .full_o  (full[r])
        );
    end

    assign bus.req_ready_o = ready;

    always_comb begin : arb_scan
        int   n_gnt;
        int   last_r;
        logic hit;
        pop      = '0;
        we_d     = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        n_gnt    = 0;
        last_r   = 0;
        hit      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (j == (int'(rr_ptr_q) + i) % N_REQ && !empty[j] && n_gnt < N_WP) begin
                    // Collision against ports already claimed earlier in this scan.
                    hit = 1'b0;
                    for (int k = 0; k < N_WP; k++) begin
                        if (k < n_gnt && addr_d[k] == head[j].addr) begin
                            hit = 1'b1;
                        end
                    end
                    if (!hit) begin
                        pop[j] = 1'b1;
                        for (int k = 0; k < N_WP; k++) begin
                            if (k == n_gnt) begin
                                we_d[k]   = 1'b1;
                                addr_d[k] = head[j].addr;
                                data_d[k] = head[j].data;
                            end
                        end
                        n_gnt  = n_gnt + 1;
                        last_r = j;
                    end
                end
            end
        end
        rr_ptr_d = (n_gnt != 0) ? RRW'((last_r + 1) % N_REQ) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q     <= '0;
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            rr_ptr_q <= '0;
        end else if (bus.flush_i) begin
            we_q <= '0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar k = 0; k < N_WP; k++) begin : g_port
        assign bus.addr_wr_o[k*SRAM_INDEX +: SRAM_INDEX] = addr_q[k];
        assign bus.data_wr_o[k*SRAM_WIDTH +: SRAM_WIDTH] = data_q[k];
    end

    assign bus.we_o   = we_q;
    assign bus.busy_o = reset & ((|(~empty)) | (|we_q));

endmodule

// File: tb/tb_sram_wr_port_arbiter.sv
// Directed bench for sram_wr_port_arbiter with an SRAM model fed from the write ports.
module tb_sram_wr_port_arbiter;

    localparam int NR = 6;
    localparam int NW = 4;
    localparam int IW = 4;
    localparam int DW = 8;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic [NR-1:0]    vld  = '0;
    logic [NR*IW-1:0] a_pk = '0;
    logic [NR*DW-1:0] d_pk = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mdl    [16];
    int            wr_cnt [16];

    sram_wr_port_arbiter_if #(.N_REQ(NR), .N_WP(NW), .SRAM_INDEX(IW), .SRAM_WIDTH(DW)) bus ();

    assign bus.flush_i     = flush;
    assign bus.req_valid_i = vld;
    assign bus.req_addr_i  = a_pk;
    assign bus.req_data_i  = d_pk;

    sram_wr_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [IW-1:0] a, input logic [DW-1:0] d);
        vld[r]           = 1'b1;
        a_pk[r*IW +: IW] = a;
        d_pk[r*DW +: DW] = d;
    endtask

    // SRAM model plus same-index collision check on every cycle that writes.
    always @(negedge clk) begin
        logic dup;
        dup = 1'b0;
        if (reset) begin
            for (int p = 0; p < NW; p++) begin
                if (bus.we_o[p]) begin
                    for (int q = 0; q < p; q++) begin
                        if (bus.we_o[q] && bus.addr_wr_o[q*IW +: IW] == bus.addr_wr_o[p*IW +: IW])
                            dup = 1'b1;
                    end
                    mdl[bus.addr_wr_o[p*IW +: IW]]    = bus.data_wr_o[p*DW +: DW];
                    wr_cnt[bus.addr_wr_o[p*IW +: IW]] = wr_cnt[bus.addr_wr_o[p*IW +: IW]] + 1;
                end
            end
            if (bus.we_o != '0) chk("no_dup_addr", 32'(dup), 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mdl[i]    = '0;
            wr_cnt[i] = 0;
        end

        // reset held low with all requesters valid
        vld = '1;
        step();
        step();
        chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_we",    32'(bus.we_o),        32'h0);
        chk("rst_busy",  32'(bus.busy_o),      32'h0);
        vld   = '0;
        reset = 1'b1;
        step();
        chk("rst_rel_ready", 32'(bus.req_ready_o), 32'h3f);
        chk("rst_rel_busy",  32'(bus.busy_o),      32'h0);

        // single request, two-edge latency
        set_req(2, 4'd5, 8'hA5);
        step();
        vld = '0;
        chk("single_early_we", 32'(bus.we_o),   32'h0);
        chk("single_busy",     32'(bus.busy_o), 32'h1);
        step();
        chk("single_we",   32'(bus.we_o),            32'h1);
        chk("single_addr", 32'(bus.addr_wr_o[3:0]),  32'h5);
        chk("single_data", 32'(bus.data_wr_o[7:0]),  32'hA5);
        step();
        chk("single_done_we",   32'(bus.we_o),   32'h0);
        chk("single_done_busy", 32'(bus.busy_o), 32'h0);

        // reset while an entry is pending: entry is lost, rr_ptr back to 0
        set_req(3, 4'd6, 8'hEE);
        step();
        vld   = '0;
        reset = 1'b0;
        step();
        chk("midrst_we",    32'(bus.we_o),        32'h0);
        chk("midrst_ready", 32'(bus.req_ready_o), 32'h0);
        chk("midrst_busy",  32'(bus.busy_o),      32'h0);
        reset = 1'b1;
        step();
        chk("midrst_rel_we",   32'(bus.we_o),   32'h0);
        chk("midrst_rel_busy", 32'(bus.busy_o), 32'h0);
        step();
        chk("midrst_after_we", 32'(bus.we_o), 32'h0);

        // all six requesters, two entries each, distinct addresses
        for (int r = 0; r < NR; r++) set_req(r, 4'(r), 8'(8'h10 + r));
        step();
        for (int r = 0; r < NR; r++) set_req(r, 4'(8 + r), 8'(8'h20 + r));
        step();
        vld = '0;
        chk("all_c1_we",    32'(bus.we_o),        32'hf);
        chk("all_c1_addr",  32'(bus.addr_wr_o),   32'h3210);
        chk("all_c1_data",  32'(bus.data_wr_o),   32'h13121110);
        chk("all_c1_ready", 32'(bus.req_ready_o), 32'h0f);
        step();
        chk("all_c2_we",   32'(bus.we_o),      32'hf);
        chk("all_c2_addr", 32'(bus.addr_wr_o), 32'h9854);
        chk("all_c2_data", 32'(bus.data_wr_o), 32'h21201514);
        step();
        chk("all_c3_we",   32'(bus.we_o),      32'hf);
        chk("all_c3_addr", 32'(bus.addr_wr_o), 32'hdcba);
        chk("all_c3_data", 32'(bus.data_wr_o), 32'h25242322);
        step();
        chk("all_done_we",   32'(bus.we_o),   32'h0);
        chk("all_done_busy", 32'(bus.busy_o), 32'h0);

        // same-address collision between r0 and r1 (rr_ptr = 0)
        set_req(0, 4'd3, 8'h30);
        set_req(1, 4'd3, 8'h31);
        step();
        vld = '0;
        step();
        chk("coll_c1_we",   32'(bus.we_o),           32'h1);
        chk("coll_c1_addr", 32'(bus.addr_wr_o[3:0]), 32'h3);
        chk("coll_c1_data", 32'(bus.data_wr_o[7:0]), 32'h30);
        step();
        chk("coll_c2_we",   32'(bus.we_o),           32'h1);
        chk("coll_c2_addr", 32'(bus.addr_wr_o[3:0]), 32'h3);
        chk("coll_c2_data", 32'(bus.data_wr_o[7:0]), 32'h31);
        step();
        chk("coll_done_we", 32'(bus.we_o), 32'h0);

        // backpressure: r0 head collides with r4 then r5 (rr_ptr = 2)
        set_req(0, 4'd7, 8'h70);
        set_req(4, 4'd7, 8'h40);
        set_req(5, 4'd7, 8'h50);
        step();
        vld = 6'b000001;
        d_pk[7:0] = 8'h71;
        chk("bp_ready_one", 32'(bus.req_ready_o[0]), 32'h1);
        step();
        d_pk[7:0] = 8'h72;
        chk("bp_c1_we",    32'(bus.we_o),           32'h1);
        chk("bp_c1_data",  32'(bus.data_wr_o[7:0]), 32'h40);
        chk("bp_full_c1",  32'(bus.req_ready_o[0]), 32'h0);
        step();
        chk("bp_c2_data",  32'(bus.data_wr_o[7:0]), 32'h50);
        chk("bp_full_c2",  32'(bus.req_ready_o[0]), 32'h0);
        step();
        chk("bp_c3_data",  32'(bus.data_wr_o[7:0]), 32'h70);
        chk("bp_ready_c3", 32'(bus.req_ready_o[0]), 32'h1);
        step();
        vld = '0;
        chk("bp_c4_data",  32'(bus.data_wr_o[7:0]), 32'h71);
        step();
        chk("bp_c5_we",    32'(bus.we_o),           32'h1);
        chk("bp_c5_data",  32'(bus.data_wr_o[7:0]), 32'h72);
        step();
        chk("bp_done_we",   32'(bus.we_o),   32'h0);
        chk("bp_done_busy", 32'(bus.busy_o), 32'h0);

        // flush with queued entries and a same-cycle push (rr_ptr = 1)
        for (int r = 0; r < NR; r++) set_req(r, 4'hE, 8'(8'h60 + r));
        step();
        for (int r = 0; r < NR; r++) set_req(r, 4'hE, 8'(8'h68 + r));
        step();
        chk("fl_pre_we",    32'(bus.we_o),           32'h1);
        chk("fl_pre_addr",  32'(bus.addr_wr_o[3:0]), 32'he);
        chk("fl_pre_data",  32'(bus.data_wr_o[7:0]), 32'h61);
        chk("fl_pre_ready", 32'(bus.req_ready_o),    32'h02);
        vld = '0;
        set_req(1, 4'hF, 8'h99);
        flush = 1'b1;
        step();
        flush = 1'b0;
        vld   = '0;
        chk("fl_we",    32'(bus.we_o),        32'h0);
        chk("fl_busy",  32'(bus.busy_o),      32'h0);
        chk("fl_ready", 32'(bus.req_ready_o), 32'h3f);
        step();
        chk("fl_after1_we", 32'(bus.we_o), 32'h0);
        step();
        chk("fl_after2_we", 32'(bus.we_o), 32'h0);

        // final SRAM contents and write counts
        chk("mem_0",    32'(mdl[0]),       32'h10);
        chk("mem_3",    32'(mdl[3]),       32'h31);
        chk("cnt_3",    32'(wr_cnt[3]),    32'd3);
        chk("mem_5",    32'(mdl[5]),       32'h15);
        chk("cnt_5",    32'(wr_cnt[5]),    32'd2);
        chk("cnt_6",    32'(wr_cnt[6]),    32'd0);
        chk("mem_7",    32'(mdl[7]),       32'h72);
        chk("cnt_7",    32'(wr_cnt[7]),    32'd5);
        chk("mem_d",    32'(mdl[13]),      32'h25);
        chk("mem_e",    32'(mdl[14]),      32'h61);
        chk("cnt_e",    32'(wr_cnt[14]),   32'd1);
        chk("cnt_f",    32'(wr_cnt[15]),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
